// File: rtl/led_stream_receiver_pkg.sv
// Shared APA102 stream definitions used by both the LED driver and the receiver.
package CCHW;

   localparam int         APA_START_BITS = 32;
   localparam int         APA_FRAME_BITS = 32;
   localparam logic [2:0] APA_HEADER     = 3'b111;

   typedef enum logic [1:0] {
      HUNT,
      LED,
      END
   } RxState_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_HEADER    = 2'd1,
      ERR_SHORT_END = 2'd2,
      ERR_TIMEOUT   = 2'd3
   } RxErr_t;

   // One LED frame as it appears on the wire, MSB first.
   typedef struct packed {
      logic [2:0] header;
      logic [4:0] bright;
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } LedFrame_t;

   // Wire order is B,G,R; consumers want {R,G,B}.
   function automatic logic [23:0] frame_rgb(input LedFrame_t f);
      return {f.r, f.g, f.b};
   endfunction

endpackage

// File: rtl/led_stream_receiver_edge_sampler.sv
// Registers the two-wire stream into the system clock domain and flags
// each rising edge of the serial clock as a bit event.
module edge_sampler (
   input  logic clk_i,
   input  logic rst_i,
   input  logic dIn_i,
   input  logic clkIn_i,
   output logic bitEvent_o,
   output logic bitVal_o
);

   logic dIn_q;
   logic clkIn_q;
   logic clkIn2_q;

   // Single register on data, two on the serial clock for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dIn_q    <= 1'b0;
         clkIn_q  <= 1'b0;
         clkIn2_q <= 1'b0;
      end else begin
         dIn_q    <= dIn_i;
         clkIn_q  <= clkIn_i;
         clkIn2_q <= clkIn_q;
      end
   end

   // dIn_q was captured alongside the high clkIn sample, so it is the bit.
   assign bitEvent_o = clkIn_q & ~clkIn2_q;
   assign bitVal_o   = dIn_q;

endmodule

// File: rtl/led_stream_receiver.sv
// Decodes an APA102-style dOut/clkOut stream back into per-LED colour words.
// Acts as a cycle-accurate strip model: start frame of zeros, LEDS frames,
// then an end frame of ones; errors and timeouts return to hunting.
module led_stream_receiver
   import CCHW::*;
#(
   parameter int LEDS         = 50,
   parameter int END_BITS     = 25,
   parameter int IDLE_TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dIn,
   input  logic                     clkIn,
   output logic                     ledValid,
   output logic [$clog2(LEDS)-1:0]  ledIndex,
   output logic [23:0]              ledRGB,
   output logic [4:0]               ledBright,
   output logic                     frameDone,
   output logic                     frameError,
   output logic [1:0]               errCode
);

   localparam int IW = $clog2(LEDS);
   localparam int CW = $clog2(LEDS + 1);
   localparam int OW = $clog2(END_BITS + 1);
   localparam int TW = $clog2(IDLE_TIMEOUT);
   localparam int ZW = $clog2(APA_START_BITS + 1);
   localparam int BW = $clog2(APA_FRAME_BITS);

   logic bitEvent;
   logic bitVal;

   edge_sampler u_sampler (
      .clk_i      (clk),
      .rst_i      (rst),
      .dIn_i      (dIn),
      .clkIn_i    (clkIn),
      .bitEvent_o (bitEvent),
      .bitVal_o   (bitVal)
   );

   RxState_t                  state_q,   state_d;
   logic [ZW-1:0]             zeroCnt_q, zeroCnt_d;
   logic [BW-1:0]             bitCnt_q,  bitCnt_d;
   // Only 31 bits are held: the 32nd bit joins them on the completing event.
   logic [APA_FRAME_BITS-2:0] sr_q,      sr_d;
   logic [CW-1:0]             ledCnt_q,  ledCnt_d;
   logic [OW-1:0]             oneCnt_q,  oneCnt_d;
   logic [TW-1:0]             idleCnt_q, idleCnt_d;

   logic                      ledValid_q,   ledValid_d;
   logic [IW-1:0]             ledIndex_q,   ledIndex_d;
   logic [23:0]               ledRGB_q,     ledRGB_d;
   logic [4:0]                ledBright_q,  ledBright_d;
   logic                      frameDone_q,  frameDone_d;
   logic                      frameError_q, frameError_d;
   logic [1:0]                errCode_q,    errCode_d;

   LedFrame_t frame;
   logic      idleHit;

   assign frame   = LedFrame_t'({sr_q, bitVal});
   assign idleHit = (idleCnt_q == TW'(IDLE_TIMEOUT - 1));

   // Next-state and output decode; a bit event always takes priority over timeout.
   always_comb begin
      state_d      = state_q;
      zeroCnt_d    = zeroCnt_q;
      bitCnt_d     = bitCnt_q;
      sr_d         = sr_q;
      ledCnt_d     = ledCnt_q;
      oneCnt_d     = oneCnt_q;
      ledValid_d   = 1'b0;
      ledIndex_d   = ledIndex_q;
      ledRGB_d     = ledRGB_q;
      ledBright_d  = ledBright_q;
      frameDone_d  = 1'b0;
      frameError_d = 1'b0;
      errCode_d    = errCode_q;

      if (bitEvent)      idleCnt_d = '0;
      else if (!idleHit) idleCnt_d = idleCnt_q + TW'(1);
      else               idleCnt_d = idleCnt_q;

      case (state_q)
         HUNT: begin
            if (bitEvent) begin
               if (!bitVal) begin
                  if (zeroCnt_q != ZW'(APA_START_BITS)) zeroCnt_d = zeroCnt_q + ZW'(1);
               end else if (zeroCnt_q == ZW'(APA_START_BITS)) begin
                  // This '1' is the top header bit of LED 0.
                  state_d  = LED;
                  sr_d     = (APA_FRAME_BITS - 1)'(1);
                  bitCnt_d = BW'(1);
                  ledCnt_d = '0;
               end else begin
                  zeroCnt_d = '0;
               end
            end
         end

         LED: begin
            if (bitEvent) begin
               sr_d = {sr_q[APA_FRAME_BITS-3:0], bitVal};
               if (bitCnt_q == BW'(APA_FRAME_BITS - 1)) begin
                  bitCnt_d = '0;
                  if (frame.header != APA_HEADER) begin
                     frameError_d = 1'b1;
                     errCode_d    = ERR_HEADER;
                     state_d      = HUNT;
                     zeroCnt_d    = '0;
                  end else begin
                     ledValid_d  = 1'b1;
                     ledIndex_d  = ledCnt_q[IW-1:0];
                     ledRGB_d    = frame_rgb(frame);
                     ledBright_d = frame.bright;
                     ledCnt_d    = ledCnt_q + CW'(1);
                     if (ledCnt_q == CW'(LEDS - 1)) begin
                        state_d  = END;
                        oneCnt_d = '0;
                     end
                  end
               end else begin
                  bitCnt_d = bitCnt_q + BW'(1);
               end
            end else if (idleHit) begin
               frameError_d = 1'b1;
               errCode_d    = ERR_TIMEOUT;
               state_d      = HUNT;
               zeroCnt_d    = '0;
            end
         end

         END: begin
            if (bitEvent) begin
               if (bitVal) begin
                  if (oneCnt_q == OW'(END_BITS - 1)) begin
                     frameDone_d = 1'b1;
                     state_d     = HUNT;
                     zeroCnt_d   = '0;
                  end else begin
                     oneCnt_d = oneCnt_q + OW'(1);
                  end
               end else begin
                  // The offending '0' already counts toward the next start frame.
                  frameError_d = 1'b1;
                  errCode_d    = ERR_SHORT_END;
                  state_d      = HUNT;
                  zeroCnt_d    = ZW'(1);
               end
            end else if (idleHit) begin
               frameError_d = 1'b1;
               errCode_d    = ERR_TIMEOUT;
               state_d      = HUNT;
               zeroCnt_d    = '0;
            end
         end

         default: state_d = HUNT;
      endcase
   end

   // State, counters and registered outputs; reset drops any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         zeroCnt_q    <= '0;
         bitCnt_q     <= '0;
         sr_q         <= '0;
         ledCnt_q     <= '0;
         oneCnt_q     <= '0;
         idleCnt_q    <= '0;
         ledValid_q   <= 1'b0;
         ledIndex_q   <= '0;
         ledRGB_q     <= '0;
         ledBright_q  <= '0;
         frameDone_q  <= 1'b0;
         frameError_q <= 1'b0;
         errCode_q    <= '0;
      end else begin
         state_q      <= state_d;
         zeroCnt_q    <= zeroCnt_d;
         bitCnt_q     <= bitCnt_d;
         sr_q         <= sr_d;
         ledCnt_q     <= ledCnt_d;
         oneCnt_q     <= oneCnt_d;
         idleCnt_q    <= idleCnt_d;
         ledValid_q   <= ledValid_d;
         ledIndex_q   <= ledIndex_d;
         ledRGB_q     <= ledRGB_d;
         ledBright_q  <= ledBright_d;
         frameDone_q  <= frameDone_d;
         frameError_q <= frameError_d;
         errCode_q    <= errCode_d;
      end
   end

   assign ledValid   = ledValid_q;
   assign ledIndex   = ledIndex_q;
   assign ledRGB     = ledRGB_q;
   assign ledBright  = ledBright_q;
   assign frameDone  = frameDone_q;
   assign frameError = frameError_q;
   assign errCode    = errCode_q;

endmodule

// File: tb/tb_led_stream_receiver.sv
// Bench for led_stream_receiver: builds randomized APA102 streams and
// predicts decoded LEDs, done pulses and error codes from how each stream
// was constructed.
module tb_led_stream_receiver;

   localparam int LEDS         = 50;
   localparam int END_BITS     = 25;
   localparam int IDLE_TIMEOUT = 4096;
   localparam int IW           = $clog2(LEDS);

   logic          clk = 1'b0;
   logic          rst;
   logic          dIn;
   logic          clkIn;
   logic          ledValid;
   logic [IW-1:0] ledIndex;
   logic [23:0]   ledRGB;
   logic [4:0]    ledBright;
   logic          frameDone;
   logic          frameError;
   logic [1:0]    errCode;

   always #5 clk = ~clk;

   led_stream_receiver #(
      .LEDS(LEDS), .END_BITS(END_BITS), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .dIn(dIn), .clkIn(clkIn),
      .ledValid(ledValid), .ledIndex(ledIndex), .ledRGB(ledRGB),
      .ledBright(ledBright), .frameDone(frameDone), .frameError(frameError),
      .errCode(errCode)
   );

   typedef struct {
      int          idx;
      logic [23:0] rgb;
      logic [4:0]  br;
      int          cyc;
   } led_ev_t;

   // Observed events (written only by the monitor) and expected events.
   led_ev_t obsLed[$];
   int      obsErrCode[$];
   int      obsErrCyc[$];
   int      obsDone = 0;
   led_ev_t expLed[$];
   int      expErr[$];
   int      expDone = 0;
   int      ledRd = 0, errRd = 0, doneRd = 0;

   int cyc = 0;
   int lastRise = 0;
   int vectors = 0;
   int miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ledValid) obsLed.push_back('{int'(ledIndex), ledRGB, ledBright, cyc});
      if (frameDone) obsDone++;
      if (frameError) begin
         obsErrCode.push_back(int'(errCode));
         obsErrCyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One serial bit: clkIn low with new data, then a rising edge.
   task automatic send_bit(input logic b);
      int lo;
      int hi;
      lo = $urandom_range(1, 2);
      hi = $urandom_range(1, 2);
      @(negedge clk);
      dIn   = b;
      clkIn = 1'b0;
      repeat (lo - 1) @(negedge clk);
      @(negedge clk);
      clkIn    = 1'b1;
      lastRise = cyc;
      repeat (hi - 1) @(negedge clk);
   endtask

   task automatic send_run(input logic b, input int n);
      for (int i = 0; i < n; i++) send_bit(b);
   endtask

   // Sends the top nbits of one LED frame; a complete frame with a good
   // header is expected to decode 1 clk after its last bit event.
   task automatic send_led(input int idx, input logic [2:0] hdr, input logic [4:0] br,
                           input logic [23:0] rgb, input int nbits);
      logic [31:0] w;
      w = {hdr, br, rgb[7:0], rgb[15:8], rgb[23:16]};
      for (int i = 31; i >= 32 - nbits; i--) send_bit(w[i]);
      if (nbits == 32 && hdr == 3'b111) expLed.push_back('{idx, rgb, br, lastRise});
   endtask

   task automatic send_good_led(input int idx);
      send_led(idx, 3'b111, 5'($urandom), 24'($urandom), 32);
   endtask

   task automatic send_body(input bit fixed);
      for (int i = 0; i < LEDS; i++) begin
         if (fixed) send_led(i, 3'b111, 5'd31, 24'h030201, 32);
         else       send_good_led(i);
      end
   endtask

   task automatic send_stream(input int zeros, input int ones, input bit fixed);
      send_run(1'b0, zeros);
      send_body(fixed);
      send_run(1'b1, ones);
      expDone++;
   endtask

   task automatic settle_and_compare(input string tag);
      int      nl, ne, nd;
      led_ev_t o, e;
      repeat (8) @(negedge clk);
      nl = obsLed.size() - ledRd;
      ne = obsErrCode.size() - errRd;
      nd = obsDone - doneRd;
      chk({tag, ".ledCount"}, nl, expLed.size());
      for (int i = 0; i < expLed.size() && i < nl; i++) begin
         o = obsLed[ledRd + i];
         e = expLed[i];
         chk($sformatf("%s.idx[%0d]", tag, i), o.idx, e.idx);
         chk($sformatf("%s.rgb[%0d]", tag, i), o.rgb, e.rgb);
         chk($sformatf("%s.bright[%0d]", tag, i), o.br, e.br);
         // Bit event occupies the cycle after the rise is sampled; ledValid follows it.
         chk($sformatf("%s.latency[%0d]", tag, i), o.cyc - e.cyc, 2);
      end
      chk({tag, ".errCount"}, ne, expErr.size());
      for (int i = 0; i < expErr.size() && i < ne; i++)
         chk($sformatf("%s.errCode[%0d]", tag, i), obsErrCode[errRd + i], expErr[i]);
      chk({tag, ".doneCount"}, nd, expDone);
      ledRd  += nl;
      errRd  += ne;
      doneRd += nd;
      expLed.delete();
      expErr.delete();
      expDone = 0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, ".ledValid"}, ledValid, 0);
      chk({tag, ".ledIndex"}, ledIndex, 0);
      chk({tag, ".ledRGB"}, ledRGB, 0);
      chk({tag, ".ledBright"}, ledBright, 0);
      chk({tag, ".frameDone"}, frameDone, 0);
      chk({tag, ".frameError"}, frameError, 0);
      chk({tag, ".errCode"}, errCode, 0);
   endtask

   initial begin
      int k, m, t0;
      logic [23:0] lastRgb;

      rst   = 1'b1;
      dIn   = 1'b0;
      clkIn = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;

      // Minimal start frame, fixed colour pattern, exact end frame.
      send_stream(32, END_BITS, 1'b1);
      settle_and_compare("clean32");
      chk("clean32.holdRGB", ledRGB, 24'h030201);
      chk("clean32.holdIdx", ledIndex, LEDS - 1);
      chk("clean32.errCode", errCode, 0);

      // Longer start frame, random colours, surplus end ones.
      send_stream(40, END_BITS + $urandom_range(0, 8), 1'b0);
      lastRgb = expLed[LEDS-1].rgb;
      settle_and_compare("zeros40");
      chk("zeros40.holdRGB", ledRGB, lastRgb);

      // Bad header on LED k, then a clean stream.
      k = $urandom_range(1, LEDS - 1);
      send_run(1'b0, 32);
      for (int i = 0; i < k; i++) send_good_led(i);
      send_led(k, 3'($urandom_range(0, 6)), 5'($urandom), 24'($urandom), 32);
      expErr.push_back(1);
      settle_and_compare("badHdr");
      chk("badHdr.errCode", errCode, 1);
      send_stream(32, END_BITS, 1'b0);
      settle_and_compare("afterBadHdr");
      chk("afterBadHdr.errHeld", errCode, 1);

      // Short end frame; its '0' is the first of only 32 start zeros.
      m = $urandom_range(1, END_BITS - 1);
      send_run(1'b0, 32);
      send_body(1'b0);
      send_run(1'b1, m);
      send_bit(1'b0);
      expErr.push_back(2);
      send_run(1'b0, 31);
      send_body(1'b0);
      send_run(1'b1, END_BITS);
      expDone++;
      settle_and_compare("shortEnd");
      chk("shortEnd.errCode", errCode, 2);

      // Serial clock stops after bit 12 of LED 3.
      send_run(1'b0, 32);
      for (int i = 0; i < 3; i++) send_good_led(i);
      send_led(3, 3'b111, 5'($urandom), 24'($urandom), 12);
      t0 = lastRise;
      @(negedge clk);
      clkIn = 1'b0;
      repeat (5000) @(negedge clk);
      expErr.push_back(3);
      settle_and_compare("timeout");
      // idleCnt is 0 two cycles after the rise and reaches IDLE_TIMEOUT-1
      // IDLE_TIMEOUT-1 cycles later; the error pulse is registered one cycle on.
      if (obsErrCyc.size() > 0)
         chk("timeout.cycle", obsErrCyc[obsErrCyc.size()-1] - t0, IDLE_TIMEOUT + 2);
      chk("timeout.errCode", errCode, 3);
      chk("timeout.holdIdx", ledIndex, 2);
      send_stream(32, END_BITS, 1'b0);
      settle_and_compare("afterTimeout");

      // Reset in the middle of LED 20, then a fresh stream.
      send_run(1'b0, 32);
      for (int i = 0; i < 20; i++) send_good_led(i);
      send_led(20, 3'b111, 5'($urandom), 24'($urandom), 15);
      @(negedge clk);
      rst   = 1'b1;
      clkIn = 1'b0;
      @(negedge clk);
      chk_outputs_zero("midReset");
      rst = 1'b0;
      settle_and_compare("preReset");
      send_stream(32, END_BITS, 1'b0);
      settle_and_compare("afterReset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_stream_receiver.md
Name: led_stream_receiver

Overview:
- Receive-side counterpart of LVDriver: decodes the APA102-style two-wire LED stream (dOut/clkOut) back into per-LED colour words.
- Sits in benches and in the loopback/self-check path to check driver output against expected rgb values.
- Acts as a cycle-accurate model of the LED strip; all logic runs on the system clock, with clkOut treated as a sampled data signal.

Parameters:
- LEDS, 50, number of LED frames per update; must match the driver.
- END_BITS, 25, minimum count of '1' bits in the end frame, equal to ceil(LEDS/2).
- IDLE_TIMEOUT, 4096, clk cycles without a clkIn rising edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dIn  in  1  serial data; connect to LVDriver dOut.
- clkIn  in  1  serial clock; connect to LVDriver clkOut.
- ledValid  out  1  one-cycle pulse when an LED frame is decoded.
- ledIndex  out  $clog2(LEDS)  index of the decoded LED, 0-based in stream order.
- ledRGB  out  24  decoded colour as {R[23:16], G[15:8], B[7:0]}.
- ledBright  out  5  global-brightness field of the frame.
- frameDone  out  1  one-cycle pulse when a complete update (start, LEDS frames, end) is accepted.
- frameError  out  1  one-cycle pulse on a header error, short end frame, or timeout.
- errCode  out  2  meaning: 0 none, 1 bad header, 2 short end frame, 3 timeout; held until the next error or reset.

Behaviour:
- Input stage:
  - dIn and clkIn are registered once (dQ, cQ); cQ is registered again (cQ2).
  - A bit event is cQ && !cQ2; on that cycle the bit sampled is dQ.
  - Stream format is MSB first; data is stable on the clkIn rising edge.
- Reset: all outputs 0; state HUNT; all counters 0. If rst is asserted mid-frame, the partial frame is discarded and no pulse is generated.
- HUNT state:
  - Counts consecutive '0' bits in zeroCnt, saturating at 32.
  - A '1' bit while zeroCnt < 32 clears zeroCnt.
  - A '1' bit while zeroCnt == 32 moves to LED. That bit is header bit 31; shift register loads 1, bitCnt = 1, ledCnt = 0.
- LED state:
  - Shifts bits into a 32-bit register; bitCnt counts 0..31.
  - After the 32nd bit, check header bits [31:29] == 3'b111:
    - Fail: frameError pulse, errCode = 1, go to HUNT with zeroCnt = 0.
    - Pass: next cycle assert ledValid with ledBright = sr[28:24], ledRGB = {sr[7:0], sr[15:8], sr[23:16]}, ledIndex = ledCnt. Then ledCnt++.
  - When ledCnt reaches LEDS, go to END with oneCnt = 0.
  - Latency: ledValid is asserted exactly 1 clk after the bit event of the 32nd bit.
- END state:
  - Counts '1' bits in oneCnt, saturating at END_BITS.
  - When oneCnt reaches END_BITS: frameDone pulse 1 clk later, go to HUNT with zeroCnt = 0.
  - A '0' bit before END_BITS is reached: frameError pulse, errCode = 2, go to HUNT with zeroCnt = 1, so that zero counts toward the next start frame.
  - '1' bits beyond END_BITS are absorbed by HUNT, since they clear zeroCnt.
- Timeout:
  - idleCnt clears on every bit event and increments otherwise, saturating.
  - In LED or END, idleCnt == IDLE_TIMEOUT-1 triggers frameError pulse, errCode = 3, go to HUNT.
  - HUNT never times out.
- Simultaneous events:
  - Bit events are at least 2 clk apart, because clkIn is generated in the same clock domain at half rate or slower; pulses therefore never overlap.
  - A timeout and a bit event on the same cycle: the bit event wins.
- Pulse outputs (ledValid, frameDone, frameError) are high for exactly 1 clk. ledRGB, ledBright and ledIndex hold their value until the next ledValid.

Decomposition:
- Add to package CCHW:
  - localparams APA_START_BITS = 32, APA_FRAME_BITS = 32, APA_HEADER = 3'b111.
  - enum RxState_t {HUNT, LED, END}.
  - typedef LedFrame_t packed struct {header[2:0], bright[4:0], b[7:0], g[7:0], r[7:0]}.
- These constants are shared with LVDriver so both ends use one definition.
- One sub-module is natural: edge_sampler, which holds the input registers and produces the bitEvent and bitVal outputs.

Test Plan:
- 32 zeros, then LEDS frames {111, 11111, B=0x01, G=0x02, R=0x03}, then 25 ones -> 50 ledValid pulses, ledIndex 0..49, ledRGB = 0x030201, ledBright = 31, one frameDone pulse, no frameError.
- Same stream with 40 leading zeros -> identical decode; the extra zeros are absorbed.
- LED 7 header 3'b110 -> 7 ledValid pulses, then frameError with errCode = 1, no frameDone. A following clean stream decodes fully.
- End frame of 10 ones, then '0' -> frameError with errCode = 2. The next start frame still decodes, with the '0' counted as a start bit.
- clkIn stops for 5000 clk after bit 12 of LED 3 -> frameError with errCode = 3 at idle cycle 4096, state HUNT.
- LVDriver loopback using testNotePositions/testNoteAmplitudes -> 50 ledValid pulses with colours matching the driver's rgb/LEDCounts expansion, frameDone before the driver's done.
- rst asserted mid-LED 20 -> all outputs 0 next clk. A fresh stream decodes with ledIndex restarting at 0.
